// File: rtl/ws2812_tx.sv
// WS2812 serialiser: takes 24-bit GRB words over valid/ready and drives NRZ pulse-width bits,
// then a latch period per frame; aborts a stalled partial frame after TRESET idle cycles.
module ws2812_tx #(
    parameter int LED_CNT = 14,
    parameter int T0H     = 20,
    parameter int T1H     = 40,
    parameter int TBIT    = 63,
    parameter int TRESET  = 2750
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] pix_data_i,
    input  logic        pix_valid_i,
    output logic        pix_ready_o,
    output logic        led_o,
    output logic        busy_o,
    output logic        frame_done_o,
    output logic        underrun_o
);
    localparam int CMAX = (TBIT > TRESET) ? TBIT : TRESET;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int PW   = (LED_CNT > 1) ? $clog2(LED_CNT) : 1;

    localparam logic [CW-1:0] TBIT_LAST = CW'(TBIT - 1);
    localparam logic [CW-1:0] TRST_LAST = CW'(TRESET - 1);
    localparam logic [CW-1:0] T0H_LAST  = CW'(T0H - 1);
    localparam logic [CW-1:0] T1H_LAST  = CW'(T1H - 1);
    localparam logic [PW-1:0] PIX_LAST  = PW'(LED_CNT - 1);

    typedef enum logic [1:0] {IDLE, HIGH, LOW, LATCH} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic [4:0]    bit_idx_q, bit_idx_d;
    logic [23:0]   sh_q, sh_d;
    logic [PW-1:0] pix_cnt_q, pix_cnt_d;
    logic          led_d, busy_d, frame_done_d, underrun_d;

    logic          hs, last_bit, more_pix, idle_to;
    logic [CW-1:0] th_last;

    assign hs       = pix_valid_i & pix_ready_o;
    assign last_bit = (state_q == LOW) && (cyc_q == TBIT_LAST) && (bit_idx_q == 5'd0);
    assign more_pix = (pix_cnt_q != PIX_LAST);
    assign th_last  = sh_q[bit_idx_q] ? T1H_LAST : T0H_LAST;
    // The idle counter only matters once a frame is partly sent.
    assign idle_to  = (state_q == IDLE) && (pix_cnt_q != '0) && (cyc_q == TRST_LAST) && !hs;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cyc_q        <= '0;
            bit_idx_q    <= 5'd23;
            sh_q         <= '0;
            pix_cnt_q    <= '0;
            led_o        <= 1'b0;
            busy_o       <= 1'b0;
            frame_done_o <= 1'b0;
            underrun_o   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cyc_q        <= cyc_d;
            bit_idx_q    <= bit_idx_d;
            sh_q         <= sh_d;
            pix_cnt_q    <= pix_cnt_d;
            led_o        <= led_d;
            busy_o       <= busy_d;
            frame_done_o <= frame_done_d;
            underrun_o   <= underrun_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cyc_d     = cyc_q;
        bit_idx_d = bit_idx_q;
        sh_d      = sh_q;
        pix_cnt_d = pix_cnt_q;
        case (state_q)
            IDLE: begin
                if (hs) begin
                    sh_d      = pix_data_i;
                    bit_idx_d = 5'd23;
                    cyc_d     = '0;
                    state_d   = HIGH;
                end else if (pix_cnt_q != '0) begin
                    if (idle_to) begin
                        pix_cnt_d = '0;
                        cyc_d     = '0;
                    end else begin
                        cyc_d = cyc_q + CW'(1);
                    end
                end
            end
            HIGH: begin
                cyc_d = cyc_q + CW'(1);
                if (cyc_q == th_last) state_d = LOW;
            end
            LOW: begin
                if (cyc_q == TBIT_LAST) begin
                    cyc_d = '0;
                    if (bit_idx_q != 5'd0) begin
                        bit_idx_d = bit_idx_q - 5'd1;
                        state_d   = HIGH;
                    end else if (more_pix) begin
                        pix_cnt_d = pix_cnt_q + PW'(1);
                        // Accepting here keeps consecutive pixels gapless.
                        if (hs) begin
                            sh_d      = pix_data_i;
                            bit_idx_d = 5'd23;
                            state_d   = HIGH;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        state_d = LATCH;
                    end
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            LATCH: begin
                if (cyc_q == TRST_LAST) begin
                    cyc_d     = '0;
                    pix_cnt_d = '0;
                    state_d   = IDLE;
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pix_ready_o  = !reset && ((state_q == IDLE) || (last_bit && more_pix));
        led_d        = (state_d == HIGH);
        busy_d       = (state_d != IDLE);
        frame_done_d = (state_q == LATCH) && (cyc_q == TRST_LAST);
        underrun_d   = idle_to;
    end
endmodule

// File: tb/tb_ws2812_tx.sv
// Bench for ws2812_tx: stimulus pushes expected words/events, a led_o decoder pops and compares.
module tb_ws2812_tx;
    localparam int LED_CNT = 2;
    localparam int T0H     = 2;
    localparam int T1H     = 4;
    localparam int TBIT    = 6;
    localparam int TRESET  = 20;

    localparam int K_WORD  = 0;
    localparam int K_FRAME = 1;
    localparam int K_UNDER = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [23:0] pix_data_i = '0;
    logic        pix_valid_i = 1'b0;
    logic        pix_ready_o, led_o, busy_o, frame_done_o, underrun_o;

    typedef struct {
        int          kind;
        logic [23:0] data;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    ws2812_tx #(.LED_CNT(LED_CNT), .T0H(T0H), .T1H(T1H), .TBIT(TBIT), .TRESET(TRESET)) dut (
        .clk(clk), .reset(reset), .pix_data_i(pix_data_i), .pix_valid_i(pix_valid_i),
        .pix_ready_o(pix_ready_o), .led_o(led_o), .busy_o(busy_o),
        .frame_done_o(frame_done_o), .underrun_o(underrun_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int kind, input logic [23:0] data);
        ev_t e;
        e.kind = kind;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge right after the handshake edge, valid still high.
    task automatic start(input logic [23:0] d);
        int n = 0;
        pix_data_i  = d;
        pix_valid_i = 1'b1;
        while (!pix_ready_o && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait_timeout", 32'(n >= 1000), 32'd0);
        @(negedge clk);
    endtask

    task automatic send(input logic [23:0] d);
        start(d);
        pix_valid_i = 1'b0;
        chk("first_high_latency", 32'(led_o), 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy_o && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("busy_timeout", 32'(n >= 1000), 32'd0);
    endtask

    // Decode led_o into words; check high widths and bit-to-bit spacing inside a word.
    initial begin : monitor
        int          tick = 0;
        int          last_rise = 0;
        int          hw = 0;
        int          nbits = 0;
        logic        led_prev = 1'b0;
        logic [23:0] word = '0;
        ev_t         e;
        forever begin
            @(negedge clk);
            if (reset) begin
                nbits = 0;
                hw    = 0;
            end else begin
                if (led_o) begin
                    if (!led_prev) begin
                        if (nbits > 0) chk("bit_period", 32'(tick - last_rise), 32'(TBIT));
                        last_rise = tick;
                        hw = 0;
                    end
                    hw++;
                end else if (led_prev) begin
                    checks++;
                    if (hw != T0H && hw != T1H) begin
                        errors++;
                        $display("FAIL high_width actual=%0d expected=%0d_or_%0d", hw, T0H, T1H);
                    end
                    word = {word[22:0], (hw == T1H)};
                    nbits++;
                    if (nbits == 24) begin
                        nbits = 0;
                        if (exp_q.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL unexpected_word actual=%06h expected=none", word);
                        end else begin
                            e = exp_q.pop_front();
                            chk("event_kind_word", 32'(K_WORD), 32'(e.kind));
                            chk("word_data", 32'(word), 32'(e.data));
                        end
                    end
                end
                if (frame_done_o || underrun_o) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_event actual=frame%0d_under%0d expected=none",
                                 frame_done_o, underrun_o);
                    end else begin
                        e = exp_q.pop_front();
                        chk("event_kind", 32'(frame_done_o ? K_FRAME : K_UNDER), 32'(e.kind));
                    end
                end
            end
            led_prev = reset ? 1'b0 : led_o;
            tick++;
        end
    end

    initial begin : stim
        logic [11:0] pat;
        int          und_first, und_cnt, rdy_cnt, rdy_idx, fd_cnt, fd_idx, latch_bad, n;
        logic        busy143, busy144, led144, rdy308, led309;

        // 1: reset held with valid high
        pix_valid_i = 1'b1;
        pix_data_i  = 24'hFFFFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_led", 32'(led_o), 32'd0);
            chk("reset_ready", 32'(pix_ready_o), 32'd0);
        end
        chk("reset_busy", 32'(busy_o), 32'd0);
        reset = 1'b0;
        pix_valid_i = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 32'(pix_ready_o), 32'd1);
        chk("no_hs_during_reset", 32'(busy_o), 32'd0);

        // 2 + 4: lone word, bit shapes, return to IDLE, then underrun timeout
        push(K_WORD, 24'hAA0000);
        push(K_UNDER, 24'h0);
        send(24'hAA0000);
        pat = '0; und_first = -1; und_cnt = 0; busy143 = 0; busy144 = 1;
        for (int i = 0; i <= 170; i++) begin
            if (i > 0) @(negedge clk);
            if (i < 12) pat[11 - i] = led_o;
            if (i == 143) busy143 = busy_o;
            if (i == 144) busy144 = busy_o;
            if (underrun_o) begin
                und_cnt++;
                if (und_first < 0) und_first = i;
            end
        end
        chk("bit23_bit22_shape", 32'(pat), 32'h00000F30);
        chk("busy_last_bit_cycle", 32'(busy143), 32'd1);
        chk("idle_after_144", 32'(busy144), 32'd0);
        chk("underrun_index", 32'(und_first), 32'd164);
        chk("underrun_count", 32'(und_cnt), 32'd1);

        // 3: two words back to back, latch, frame_done; valid kept high across the latch
        push(K_WORD, 24'h5A0F3C);
        push(K_WORD, 24'hFFFFFF);
        push(K_FRAME, 24'h0);
        push(K_WORD, 24'h000001);
        start(24'h5A0F3C);
        pix_data_i = 24'hFFFFFF;
        rdy_cnt = 0; rdy_idx = -1; fd_cnt = 0; fd_idx = -1; latch_bad = 0;
        led144 = 0; rdy308 = 0; led309 = 0;
        for (int i = 0; i <= 309; i++) begin
            if (i > 0) @(negedge clk);
            if (i <= 143 && pix_ready_o) begin
                rdy_cnt++;
                rdy_idx = i;
            end
            if (i == 144) begin
                led144 = led_o;
                pix_data_i = 24'h000001;
            end
            if (i >= 288 && i <= 307 && (led_o || !busy_o || pix_ready_o)) latch_bad++;
            if (frame_done_o) begin
                fd_cnt++;
                fd_idx = i;
            end
            if (i == 308) rdy308 = pix_ready_o;
            if (i == 309) led309 = led_o;
        end
        pix_valid_i = 1'b0;
        chk("mid_frame_ready_count", 32'(rdy_cnt), 32'd1);
        chk("mid_frame_ready_index", 32'(rdy_idx), 32'd143);
        chk("gapless_second_word", 32'(led144), 32'd1);
        chk("latch_period_bad", 32'(latch_bad), 32'd0);
        chk("frame_done_count", 32'(fd_cnt), 32'd1);
        chk("frame_done_index", 32'(fd_idx), 32'd308);
        chk("ready_after_latch", 32'(rdy308), 32'd1);
        chk("next_frame_start", 32'(led309), 32'd1);

        // 5: 10-cycle gap before pixel 1, below timeout
        push(K_WORD, 24'h800081);
        push(K_FRAME, 24'h0);
        wait_idle();
        repeat (10) @(negedge clk);
        send(24'h800081);
        n = 0;
        while (!frame_done_o && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("gap_frame_done_seen", 32'(frame_done_o), 32'd1);
        chk("gap_ready_after_frame", 32'(pix_ready_o), 32'd1);

        // 6: reset during bit 5 of pixel 1
        push(K_WORD, 24'hC3A5E1);
        send(24'hC3A5E1);
        wait_idle();
        send(24'h7E7E7E);
        repeat (18 * TBIT + 2) @(negedge clk);
        chk("pre_reset_busy", 32'(busy_o), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_led", 32'(led_o), 32'd0);
        chk("abort_busy", 32'(busy_o), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_ready", 32'(pix_ready_o), 32'd1);
        fd_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (frame_done_o || underrun_o) fd_cnt++;
        end
        chk("abort_no_pulses", 32'(fd_cnt), 32'd0);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
